// File: rtl/truth_table_scanner.sv
// Sweeps every input combination of a combinational function, captures its truth table
// and streams each hit index over valid/ready. Define TTS_MAXTERM_EN to report zeros instead.
module truth_table_scanner #(
  parameter int N_VARS = 4,
  parameter int SETTLE = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     f_in,
  output logic [N_VARS-1:0]        vars,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [N_VARS-1:0]        m_data,
  output logic [(1<<N_VARS)-1:0]   mask,
  output logic [N_VARS:0]          count,
  output logic                     busy,
  output logic                     done
);

  localparam logic [N_VARS-1:0] LAST_IDX    = {N_VARS{1'b1}};
  localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_EMIT,
    ST_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [N_VARS-1:0]        idx_q, idx_d;
  logic [3:0]               settleCnt_q, settleCnt_d;
  logic [(1<<N_VARS)-1:0]   mask_q, mask_d;
  logic [N_VARS:0]          count_q, count_d;
  logic [N_VARS-1:0]        mData_q, mData_d;
  logic                     fSample;
  logic                     report;
  logic                     advance;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      settleCnt_q <= '0;
      mask_q      <= '0;
      count_q     <= '0;
      mData_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      settleCnt_q <= settleCnt_d;
      mask_q      <= mask_d;
      count_q     <= count_d;
      mData_q     <= mData_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    settleCnt_d = settleCnt_q;
    mask_d      = mask_q;
    count_d     = count_q;
    mData_d     = mData_q;
    advance     = 1'b0;

    // An undefined f_in fails the if-test, so X/Z is captured as 0.
    if (f_in) fSample = 1'b1;
    else      fSample = 1'b0;

`ifdef TTS_MAXTERM_EN
    report = ~fSample;
`else
    report = fSample;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mask_d      = '0;
          count_d     = '0;
          idx_d       = '0;
          settleCnt_d = '0;
          state_d     = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        settleCnt_d = settleCnt_q + 4'd1;
        if (settleCnt_q == SETTLE_LAST) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        mask_d[idx_q] = fSample;
        if (report) begin
          count_d = count_q + 1'b1;
          mData_d = idx_q;
          state_d = ST_EMIT;
        end else begin
          advance = 1'b1;
        end
      end
      ST_EMIT: begin
        if (m_ready) advance = 1'b1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The last index ends the scan rather than wrapping back to zero.
    if (advance) begin
      if (idx_q == LAST_IDX) begin
        state_d = ST_DONE;
      end else begin
        idx_d       = idx_q + 1'b1;
        settleCnt_d = '0;
        state_d     = ST_SETTLE;
      end
    end
  end

  assign busy    = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE) || (state_q == ST_EMIT);
  assign vars    = busy ? idx_q : '0;
  assign m_valid = (state_q == ST_EMIT);
  assign done    = (state_q == ST_DONE);
  assign m_data  = mData_q;
  assign mask    = mask_q;
  assign count   = count_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner: drives SoP(0,1,5,6,8,9,C,E) and constant
// functions into f_in and checks stream, mask, count, latency, stalls and reset abort.
module tb_truth_table_scanner;

  localparam int N_VARS = 4;
  localparam int SETTLE = 1;

`ifdef TTS_MAXTERM_EN
  localparam bit MAXTERM = 1'b1;
`else
  localparam bit MAXTERM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        f_in;
  logic [3:0]  vars;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [3:0]  m_data;
  logic [15:0] mask;
  logic [4:0]  count;
  logic        busy;
  logic        done;

  int compared = 0;
  int mismatched = 0;
  int fMode = 0;
  int expQ[$];

  truth_table_scanner #(.N_VARS(N_VARS), .SETTLE(SETTLE)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .f_in(f_in),
    .vars(vars), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .mask(mask), .count(count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Function under test: 0 = SoP(0,1,5,6,8,9,12,14), 1 = const 0, 2 = const 1, else X.
  always_comb begin
    f_in = 1'b0;
    case (fMode)
      0:       f_in = (vars inside {4'd0, 4'd1, 4'd5, 4'd6, 4'd8, 4'd9, 4'd12, 4'd14});
      1:       f_in = 1'b0;
      2:       f_in = 1'b1;
      default: f_in = 1'bx;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setSopStream();
    if (MAXTERM) expQ = '{2, 3, 4, 7, 10, 11, 13, 15};
    else         expQ = '{0, 1, 5, 6, 8, 9, 12, 14};
  endtask

  task automatic setFullStream(input bit full);
    expQ = {};
    if (full) for (int i = 0; i < 16; i++) expQ.push_back(i);
  endtask

  // Runs one scan; stall = ready-low cycles per emission, restartAt = cycle to re-pulse start.
  task automatic applyStimulus(input string tag, input int stall, input int restartAt,
                               input int expCycles, input logic [15:0] expMask,
                               input logic [4:0] expCount);
    int cycles;
    int n;
    int stallLeft;
    bit prevValid;
    bit finished;
    logic [3:0] heldData;
    cycles = 0; n = 0; stallLeft = 0; prevValid = 1'b0; finished = 1'b0; heldData = '0;
    m_ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput({tag, ".busyAfterStart"}, busy, 1);
    while (cycles < 2000) begin
      @(posedge clk);
      #1;
      cycles++;
      start = (cycles == restartAt);
      if (done) begin
        finished = 1'b1;
        break;
      end
      if (m_valid) begin
        if (!prevValid) begin
          stallLeft = stall;
          heldData  = m_data;
        end else begin
          checkOutput({tag, ".mDataStable"}, m_data, heldData);
        end
        checkOutput({tag, ".varsHeld"}, vars, heldData);
        if (stallLeft > 0) begin
          m_ready = 1'b0;
          stallLeft--;
        end else begin
          m_ready = 1'b1;
          if (n < expQ.size()) checkOutput({tag, ".mData"}, m_data, expQ[n]);
          else checkOutput({tag, ".extraTransfer"}, n, expQ.size());
          n++;
        end
      end else begin
        m_ready = 1'b1;
      end
      prevValid = m_valid;
    end
    start = 1'b0;
    checkOutput({tag, ".finished"}, finished, 1);
    checkOutput({tag, ".latency"}, cycles, expCycles);
    checkOutput({tag, ".transfers"}, n, expQ.size());
    checkOutput({tag, ".mask"}, mask, expMask);
    checkOutput({tag, ".count"}, count, expCount);
    checkOutput({tag, ".busyInDone"}, busy, 0);
    @(posedge clk);
    #1;
    checkOutput({tag, ".donePulse"}, done, 0);
    checkOutput({tag, ".maskHold"}, mask, expMask);
    checkOutput({tag, ".countHold"}, count, expCount);
  endtask

  initial begin
    int target;
    bit found;
    bit sawDone;
    target = MAXTERM ? 7 : 5;

    $display("[TB] reset");
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst.vars", vars, 0);
    checkOutput("rst.mValid", m_valid, 0);
    checkOutput("rst.mData", m_data, 0);
    checkOutput("rst.mask", mask, 0);
    checkOutput("rst.count", count, 0);
    checkOutput("rst.busy", busy, 0);
    checkOutput("rst.done", done, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] SoP scan, ready high");
    fMode = 0;
    setSopStream();
    applyStimulus("sop", 0, -1, 40, 16'h5363, 5'd8);

    $display("[TB] SoP scan, ready stalled 3 cycles");
    applyStimulus("sopStall", 3, -1, 64, 16'h5363, 5'd8);

    $display("[TB] constant 0");
    fMode = 1;
    setFullStream(MAXTERM);
    applyStimulus("zero", 0, -1, MAXTERM ? 48 : 32, 16'h0000, MAXTERM ? 5'd16 : 5'd0);

    $display("[TB] constant 1");
    fMode = 2;
    setFullStream(!MAXTERM);
    applyStimulus("one", 0, -1, MAXTERM ? 32 : 48, 16'hFFFF, MAXTERM ? 5'd0 : 5'd16);

    $display("[TB] undefined f_in");
    fMode = 3;
    setFullStream(MAXTERM);
    applyStimulus("xin", 0, -1, MAXTERM ? 48 : 32, 16'h0000, MAXTERM ? 5'd16 : 5'd0);

    $display("[TB] start re-pulsed mid-scan");
    fMode = 0;
    setSopStream();
    applyStimulus("restart", 0, 10, 40, 16'h5363, 5'd8);

    $display("[TB] reset while emitting");
    m_ready = 1'b1;
    found = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #1;
      if (m_valid && (m_data == 4'(target))) begin
        found = 1'b1;
        break;
      end
      m_ready = 1'b1;
    end
    checkOutput("abort.reachTarget", found, 1);
    m_ready = 1'b0;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    checkOutput("abort.vars", vars, 0);
    checkOutput("abort.mValid", m_valid, 0);
    checkOutput("abort.mData", m_data, 0);
    checkOutput("abort.mask", mask, 0);
    checkOutput("abort.count", count, 0);
    checkOutput("abort.busy", busy, 0);
    checkOutput("abort.done", done, 0);
    sawDone = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (done || busy) sawDone = 1'b1;
    end
    checkOutput("abort.stayIdle", sawDone, 0);

    $display("[TB] full scan after abort");
    setSopStream();
    applyStimulus("afterAbort", 0, -1, 40, 16'h5363, 5'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
